// File: rtl/rom_t_fetch.sv
// Read-side sequencer for the Chebyshev coefficient ROMs: walks addresses 0..N-1,
// drives the shared-bus ROM controls and offers each word over valid/ready.
module rom_t_fetch #(
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 8,
    parameter int WAIT_CYC = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic [3:0]        i_count,
    input  logic              i_abort,
    input  logic [DATA_W-1:0] i_rom_data,
    output logic [ADDR_W-1:0] o_rom_address,
    output logic              o_rom_ce,
    output logic              o_rom_read_en,
    output logic              o_rom_tri_output,
    output logic [DATA_W-1:0] o_coef_data,
    output logic [ADDR_W-1:0] o_coef_index,
    output logic              o_coef_valid,
    output logic              o_coef_last,
    input  logic              i_coef_ready,
    output logic              o_busy,
    output logic              o_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_OFFER,
        S_DONE
    } state_t;

    localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYC - 1);

    state_t              state, state_d;
    logic [ADDR_W-1:0]   last_addr, last_addr_d;
    logic [2:0]          wait_cnt, wait_cnt_d;
    logic [ADDR_W-1:0]   addr_d;
    logic                ce_d, read_en_d, tri_d;
    logic [DATA_W-1:0]   data_d;
    logic [ADDR_W-1:0]   index_d;
    logic                valid_d, last_d, busy_d, done_d;
    logic [ADDR_W-1:0]   count_clamped;

    // A count of zero or one larger than the table fetches the whole table.
    always_comb begin
        if (i_count == 4'd0 || int'(i_count) > DEPTH) begin
            count_clamped = ADDR_W'(DEPTH - 1);
        end else begin
            count_clamped = ADDR_W'(i_count - 4'd1);
        end
    end

    // NOTE: every signal gets its hold value first, so no path through the case
    // can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state;
        last_addr_d = last_addr;
        wait_cnt_d  = wait_cnt;
        addr_d      = o_rom_address;
        ce_d        = o_rom_ce;
        read_en_d   = o_rom_read_en;
        tri_d       = o_rom_tri_output;
        data_d      = o_coef_data;
        index_d     = o_coef_index;
        valid_d     = o_coef_valid;
        last_d      = o_coef_last;
        busy_d      = o_busy;
        done_d      = o_done;

        unique case (state)
            S_IDLE: begin
                if (i_start) begin
                    last_addr_d = count_clamped;
                    addr_d      = '0;
                    wait_cnt_d  = '0;
                    ce_d        = 1'b1;
                    read_en_d   = 1'b1;
                    tri_d       = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = S_ACCESS;
                end
            end

            S_ACCESS: begin
                if (i_abort) begin
                    state_d   = S_IDLE;
                    addr_d    = '0;
                    ce_d      = 1'b0;
                    read_en_d = 1'b0;
                    tri_d     = 1'b1;
                    valid_d   = 1'b0;
                    last_d    = 1'b0;
                    busy_d    = 1'b0;
                end else if (wait_cnt == WAIT_LAST) begin
                    data_d    = i_rom_data;
                    index_d   = o_rom_address;
                    valid_d   = 1'b1;
                    last_d    = (o_rom_address == last_addr);
                    ce_d      = 1'b0;
                    read_en_d = 1'b0;
                    tri_d     = 1'b1;
                    state_d   = S_OFFER;
                end else begin
                    wait_cnt_d = wait_cnt + 3'd1;
                end
            end

            S_OFFER: begin
                // Abort wins over a same-edge handshake; the word is dropped.
                if (i_abort) begin
                    state_d   = S_IDLE;
                    addr_d    = '0;
                    ce_d      = 1'b0;
                    read_en_d = 1'b0;
                    tri_d     = 1'b1;
                    valid_d   = 1'b0;
                    last_d    = 1'b0;
                    busy_d    = 1'b0;
                end else if (i_coef_ready) begin
                    valid_d = 1'b0;
                    if (o_coef_last) begin
                        last_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        addr_d     = o_rom_address + ADDR_W'(1);
                        wait_cnt_d = '0;
                        ce_d       = 1'b1;
                        read_en_d  = 1'b1;
                        tri_d      = 1'b0;
                        state_d    = S_ACCESS;
                    end
                end
            end

            S_DONE: begin
                done_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed above.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= S_IDLE;
            last_addr        <= '0;
            wait_cnt         <= '0;
            o_rom_address    <= '0;
            o_rom_ce         <= 1'b0;
            o_rom_read_en    <= 1'b0;
            o_rom_tri_output <= 1'b1;
            o_coef_data      <= '0;
            o_coef_index     <= '0;
            o_coef_valid     <= 1'b0;
            o_coef_last      <= 1'b0;
            o_busy           <= 1'b0;
            o_done           <= 1'b0;
        end else begin
            state            <= state_d;
            last_addr        <= last_addr_d;
            wait_cnt         <= wait_cnt_d;
            o_rom_address    <= addr_d;
            o_rom_ce         <= ce_d;
            o_rom_read_en    <= read_en_d;
            o_rom_tri_output <= tri_d;
            o_coef_data      <= data_d;
            o_coef_index     <= index_d;
            o_coef_valid     <= valid_d;
            o_coef_last      <= last_d;
            o_busy           <= busy_d;
            o_done           <= done_d;
        end
    end

endmodule
